// File: rtl/led_pattern_gen.sv
// LED pattern generator: one of five patterns (up, down, gray, bounce, fill)
// stepped at a rate derived from the system clock, with pause and mode restart.
module led_pattern_gen #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned UPDATE_FREQ = 10,
  parameter int unsigned LED_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [2:0]           mode,
  input  logic [1:0]           speed_sel,
  output logic [LED_WIDTH-1:0] led,
  output logic                 step
);

  localparam int unsigned RATIO  = CLK_FREQ / UPDATE_FREQ;
  localparam int unsigned DIV_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned POS_W  = $clog2(LED_WIDTH);
  localparam int unsigned FILL_W = $clog2(LED_WIDTH + 1);

  // Terminal divider counts per speed; a period below one cycle saturates at every-cycle.
  localparam int unsigned P0  = CLK_FREQ / (UPDATE_FREQ << 0);
  localparam int unsigned P1  = CLK_FREQ / (UPDATE_FREQ << 1);
  localparam int unsigned P2  = CLK_FREQ / (UPDATE_FREQ << 2);
  localparam int unsigned P3  = CLK_FREQ / (UPDATE_FREQ << 3);
  localparam int unsigned PM0 = (P0 > 1) ? P0 - 1 : 0;
  localparam int unsigned PM1 = (P1 > 1) ? P1 - 1 : 0;
  localparam int unsigned PM2 = (P2 > 1) ? P2 - 1 : 0;
  localparam int unsigned PM3 = (P3 > 1) ? P3 - 1 : 0;

  typedef enum logic [2:0] {
    M_UP     = 3'd0,
    M_DOWN   = 3'd1,
    M_GRAY   = 3'd2,
    M_BOUNCE = 3'd3,
    M_FILL   = 3'd4
  } mode_e;

  mode_e                 mode_eff;
  mode_e                 mode_q, mode_d;
  logic [DIV_W-1:0]      div_q, div_d, div_last;
  logic [LED_WIDTH-1:0]  cnt_q, cnt_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  dir_q, dir_d;   // 0 = moving toward MSB
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [LED_WIDTH-1:0]  led_q, led_d;
  logic                  step_q, step_d;

  assign mode_eff = (mode > 3'd4) ? M_UP : mode_e'(mode);

  always_comb begin
    div_last = DIV_W'(PM0);
    unique case (speed_sel)
      2'd0: div_last = DIV_W'(PM0);
      2'd1: div_last = DIV_W'(PM1);
      2'd2: div_last = DIV_W'(PM2);
      2'd3: div_last = DIV_W'(PM3);
      default: div_last = DIV_W'(PM0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= M_UP;
      div_q  <= '0;
      cnt_q  <= '0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      fill_q <= '0;
      led_q  <= '0;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      fill_q <= fill_d;
      led_q  <= led_d;
      step_q <= step_d;
    end
  end

  // Mode restart takes priority over a tick; pause freezes everything but step.
  always_comb begin
    mode_d = mode_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    fill_d = fill_q;
    led_d  = led_q;
    step_d = 1'b0;
    if (mode_eff != mode_q) begin
      mode_d = mode_eff;
      div_d  = '0;
      cnt_d  = (mode_eff == M_DOWN) ? '1 : '0;
      pos_d  = '0;
      dir_d  = 1'b0;
      fill_d = '0;
      if (mode_eff == M_DOWN)        led_d = '1;
      else if (mode_eff == M_BOUNCE) led_d = LED_WIDTH'(1);
      else                           led_d = '0;
    end else if (enable) begin
      if (div_q >= div_last) begin
        div_d  = '0;
        step_d = 1'b1;
        unique case (mode_q)
          M_DOWN: begin
            cnt_d = cnt_q - LED_WIDTH'(1);
            led_d = cnt_d;
          end
          M_GRAY: begin
            cnt_d = cnt_q + LED_WIDTH'(1);
            led_d = cnt_d ^ (cnt_d >> 1);
          end
          M_BOUNCE: begin
            if (!dir_q) begin
              pos_d = pos_q + POS_W'(1);
              if (pos_d == POS_W'(LED_WIDTH - 1)) dir_d = 1'b1;
            end else begin
              pos_d = pos_q - POS_W'(1);
              if (pos_d == '0) dir_d = 1'b0;
            end
            led_d = LED_WIDTH'(1) << pos_d;
          end
          M_FILL: begin
            fill_d = (fill_q == FILL_W'(LED_WIDTH)) ? '0 : fill_q + FILL_W'(1);
            for (int i = 0; i < int'(LED_WIDTH); i++) led_d[i] = (i < int'(fill_d));
          end
          default: begin
            cnt_d = cnt_q + LED_WIDTH'(1);
            led_d = cnt_d;
          end
        endcase
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at CLK_FREQ=100, UPDATE_FREQ=10, LED_WIDTH=4
// (periods 10/5/2/1 cycles for speed_sel 0..3).
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] mode;
  logic [1:0] speed_sel;
  logic [3:0] led;
  logic       step;

  int checks   = 0;
  int failures = 0;

  led_pattern_gen #(
    .CLK_FREQ   (100),
    .UPDATE_FREQ(10),
    .LED_WIDTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .mode     (mode),
    .speed_sel(speed_sel),
    .led      (led),
    .step     (step)
  );

  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] e;
    logic [3:0] bounce_exp [8];
    bounce_exp = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4};

    // Up count from reset
    rst = 1'b1; enable = 1'b1; mode = 3'd0; speed_sel = 2'd0;
    edges(2);
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_step", 32'(step), 32'h0);
    rst = 1'b0;
    edges(9);
    chk("up_pre_led", 32'(led), 32'h0);
    chk("up_pre_step", 32'(step), 32'h0);
    edges(1);
    chk("up_first_led", 32'(led), 32'h1);
    chk("up_first_step", 32'(step), 32'h1);
    edges(1);
    chk("up_step_clear", 32'(step), 32'h0);
    edges(8);
    for (int i = 1; i <= 15; i++) begin
      edges(1);
      e = 4'(i + 1);
      chk($sformatf("up_led_%0d", i), 32'(led), 32'(e));
      chk($sformatf("up_step_%0d", i), 32'(step), 32'h1);
      if (i != 15) edges(9);
    end

    // Down, mode held through reset
    rst = 1'b1; mode = 3'd1;
    edges(2);
    chk("down_reset_led", 32'(led), 32'h0);
    rst = 1'b0;
    edges(1);
    chk("down_init_led", 32'(led), 32'hF);
    chk("down_init_step", 32'(step), 32'h0);
    edges(9);
    chk("down_pre_led", 32'(led), 32'hF);
    edges(1);
    chk("down_first_led", 32'(led), 32'hE);
    chk("down_first_step", 32'(step), 32'h1);
    for (int i = 0; i < 15; i++) begin
      edges(10);
      e = 4'(13 - i);
      chk($sformatf("down_led_%0d", i), 32'(led), 32'(e));
    end

    // Bounce at one step per cycle
    mode = 3'd3; speed_sel = 2'd3;
    edges(1);
    chk("bounce_init_led", 32'(led), 32'h1);
    chk("bounce_init_step", 32'(step), 32'h0);
    for (int i = 0; i < 8; i++) begin
      edges(1);
      chk($sformatf("bounce_led_%0d", i), 32'(led), 32'(bounce_exp[i]));
      chk($sformatf("bounce_step_%0d", i), 32'(step), 32'h1);
    end

    // Fill with a speed change while the divider is past the new terminal count
    mode = 3'd4; speed_sel = 2'd0;
    edges(1);
    chk("fill_init_led", 32'(led), 32'h0);
    edges(7);
    chk("fill_pre_step", 32'(step), 32'h0);
    speed_sel = 2'd2;
    edges(1);
    chk("fill_fast_led", 32'(led), 32'h1);
    chk("fill_fast_step", 32'(step), 32'h1);
    edges(1);
    chk("fill_gap_step", 32'(step), 32'h0);
    chk("fill_gap_led", 32'(led), 32'h1);
    edges(1);
    chk("fill_led_3", 32'(led), 32'h3);
    edges(2);
    chk("fill_led_7", 32'(led), 32'h7);
    edges(2);
    chk("fill_led_f", 32'(led), 32'hF);
    edges(2);
    chk("fill_wrap_led", 32'(led), 32'h0);
    chk("fill_wrap_step", 32'(step), 32'h1);

    // Pause at led=5, div_cnt=3
    mode = 3'd0; speed_sel = 2'd0;
    edges(1);
    chk("pause_restart_led", 32'(led), 32'h0);
    edges(53);
    chk("pause_start_led", 32'(led), 32'h5);
    enable = 1'b0;
    edges(25);
    chk("pause_hold_led", 32'(led), 32'h5);
    chk("pause_hold_step", 32'(step), 32'h0);
    enable = 1'b1;
    edges(6);
    chk("resume_pre_led", 32'(led), 32'h5);
    edges(1);
    chk("resume_led", 32'(led), 32'h6);
    chk("resume_step", 32'(step), 32'h1);

    // Mode change coincident with a tick, then remapped mode 6
    edges(9);
    chk("gray_pre_led", 32'(led), 32'h6);
    mode = 3'd2;
    edges(1);
    chk("gray_init_led", 32'(led), 32'h0);
    chk("gray_init_step", 32'(step), 32'h0);
    edges(10);
    chk("gray_led_1", 32'(led), 32'h1);
    chk("gray_step_1", 32'(step), 32'h1);
    edges(10);
    chk("gray_led_3", 32'(led), 32'h3);
    edges(10);
    chk("gray_led_2", 32'(led), 32'h2);
    edges(10);
    chk("gray_led_6", 32'(led), 32'h6);
    mode = 3'd6;
    edges(1);
    chk("remap_init_led", 32'(led), 32'h0);
    chk("remap_init_step", 32'(step), 32'h0);
    edges(10);
    chk("remap_led_1", 32'(led), 32'h1);
    chk("remap_step_1", 32'(step), 32'h1);

    // Reset mid-pattern
    edges(30);
    chk("mid_pre_led", 32'(led), 32'h4);
    rst = 1'b1;
    edges(1);
    chk("mid_reset_led", 32'(led), 32'h0);
    chk("mid_reset_step", 32'(step), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the fixed 8-bit LED binary counter.
- Drives an LED_WIDTH-bit LED bank with one of five runtime-selectable patterns, at a runtime-selectable update rate derived from the system clock.
- Supports pause, and restarts the pattern cleanly on a mode change.
- Sits between board-level control (switches/PS GPIO) and the LED pins.

Parameters:
- CLK_FREQ, 100_000_000: input clock frequency in Hz.
- UPDATE_FREQ, 10: base pattern step rate in Hz (speed_sel = 0).
- LED_WIDTH, 8: number of LEDs. Legal range 2..32.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = run; 0 = pause (divider and pattern hold).
- mode  input  3  pattern select: 0 up, 1 down, 2 gray, 3 bounce, 4 fill; 5..7 behave as 0.
- speed_sel  input  2  step rate = UPDATE_FREQ << speed_sel (x1, x2, x4, x8).
- led  output  LED_WIDTH  registered LED pattern.
- step  output  1  registered one-cycle pulse, coincident with each led update.

Behaviour:
- Reset (rst=1 at a clk edge): div_cnt=0, cnt=0, pos=0, dir=up, fill=0, mode_q=0, led=0, step=0.
- Period: P = CLK_FREQ / (UPDATE_FREQ << speed_sel), integer division.
- Divider width: $clog2(CLK_FREQ/UPDATE_FREQ).
- Divider compare uses >=. A speed_sel change that leaves div_cnt >= P-1 fires on the next edge. No lockup.
- Divider, with enable=1:
  - If div_cnt >= P-1: div_cnt←0, pattern advances, step←1.
  - Else: div_cnt+1, step←0.
- enable=0: div_cnt, pattern state and led hold; step←0.
- Update latency: from a reset release (or mode restart), the first pattern advance shows on led P edges later. Steady-state spacing is exactly P cycles.
- Mode change: mode (remapped 5..7→0) is registered into mode_q every cycle. When mode differs from mode_q at an edge:
  - mode_q←mode; div_cnt←0; step←0.
  - Pattern state reinitialises and led takes the new mode's initial value at that same edge.
  - This applies regardless of enable.
- Mode change overrides a coincident tick.
- Pattern state and led per mode (W = LED_WIDTH):
  - Up: cnt+1 mod 2^W; led=cnt. Initial 0. All-ones wraps to 0.
  - Down: cnt-1 mod 2^W; led=cnt. Initial all-ones. 0 wraps to all-ones.
  - Gray: cnt+1 mod 2^W; led = cnt ^ (cnt>>1). Initial 0. Wraps from 1 followed by W-1 zeros back to 0.
  - Bounce: one-hot led = 1<<pos. Initial pos=0, dir=up.
    - pos moves one per step; dir reverses on reaching W-1 or 0.
    - End LEDs are shown once per pass; period 2W-2 steps.
  - Fill: thermometer led = (1<<fill)-1. Initial fill=0 (all off).
    - fill increments to W (all on), then wraps to 0.
    - Period W+1 steps.
- rst overrides everything, including an active mode change or tick.
- rst asserted mid-pattern returns to reset values at that edge. led=0 even if the mode input is 1; the mode-change rule then applies on the next edge.
- No combinational path from inputs to outputs.

Test Plan:
- Params CLK_FREQ=100, UPDATE_FREQ=10, LED_WIDTH=4; mode=0, speed_sel=0, enable=1; release rst -> step pulses every 10 cycles; led 0,1,2,…,15,0; first step 10 edges after release.
- mode=1 held through reset -> edge after release led=4'hF, step=0; then F,E,…,0,F every 10 cycles.
- mode=3, speed_sel=3 (P=1) -> led updates every cycle: 1,2,4,8,4,2,1,2…; step constantly 1.
- mode=4 with speed_sel changed 0→2 while div_cnt=7 (new P=2) -> step on next edge; led sequence 0,1,3,7,F,0; subsequent spacing 2 cycles.
- enable=0 for 25 cycles mid-count at led=5, div_cnt=3 -> led stays 5, step=0; after re-enable, led=6 exactly 7 cycles later.
- Switch mode 0→2 on the same edge a tick would fire, then mode=6 -> gray restarts at led=0 with no step pulse, sequence 0,1,3,2,6…; mode=6 restarts as up-count from 0.
